// File: rtl/split_sync_if.sv
// Channel bundle for split_sync: e1of2 data and control inputs, three e1of2
// output channels with their enables, and the sticky protocol-error flag.
interface split_sync_if #(
    parameter int W = 11
);
    logic [2*W-1:0] in_d;
    logic           in_e;
    logic [3:0]     ctl_d;
    logic           ctl_e;
    logic [2*W-1:0] out0_d;
    logic [2*W-1:0] out1_d;
    logic [2*W-1:0] out2_d;
    logic           out0_e;
    logic           out1_e;
    logic           out2_e;
    logic           err;

    modport master (
        output in_d, ctl_d, out0_e, out1_e, out2_e,
        input  in_e, ctl_e, out0_d, out1_d, out2_d, err
    );

    modport slave (
        input  in_d, ctl_d, out0_e, out1_e, out2_e,
        output in_e, ctl_e, out0_d, out1_d, out2_d, err
    );
endinterface

// File: rtl/split_sync.sv
// Clocked three-way split: one e1of2 data token is steered to out0/out1/out2
// according to a dual-rail control token, using the four-phase enable protocol.
module split_sync #(
    parameter int W = 11
) (
    input  logic        CLK,
    input  logic        _RESET,
    split_sync_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE_PRE = 3'd0,
        IDLE     = 3'd1,
        ACK_IN   = 3'd2,
        SEND     = 3'd3,
        OUT_ACK  = 3'd4,
        OUT_RST  = 3'd5
    } state_t;

    function automatic logic data_valid(input logic [2*W-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            ok = ok & (d[2*i] ^ d[2*i+1]);
        end
        return ok;
    endfunction

    function automatic logic data_illegal(input logic [2*W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            bad = bad | (d[2*i] & d[2*i+1]);
        end
        return bad;
    endfunction

    function automatic logic [W-1:0] data_decode(input logic [2*W-1:0] d);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) begin
            b[i] = d[2*i+1];
        end
        return b;
    endfunction

    function automatic logic [2*W-1:0] data_encode(input logic [W-1:0] b);
        logic [2*W-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) begin
            d[2*i+1] = b[i];
            d[2*i]   = ~b[i];
        end
        return d;
    endfunction

    function automatic logic ctl_valid(input logic [3:0] c);
        return (c[0] ^ c[1]) & (c[2] ^ c[3]);
    endfunction

    function automatic logic ctl_illegal(input logic [3:0] c);
        return (c[0] & c[1]) | (c[2] & c[3]);
    endfunction

    function automatic logic [1:0] ctl_decode(input logic [3:0] c);
        return {c[3], c[1]};
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   data_r;
    logic [W-1:0]   data_s;
    logic [1:0]     sel_r;
    logic [1:0]     sel_s;
    logic           err_r;
    logic           err_s;
    logic           en_r;
    logic           en_s;
    logic [2*W-1:0] out_r [3];
    logic [2*W-1:0] out_s [3];
    logic           sel_e_s;
    logic           load_s;
    logic [2*W-1:0] tok_s;
    logic           in_ok_s;
    logic           ctl_ok_s;
    logic           any_bad_s;
    logic           both_neutral_s;

    assign in_ok_s        = data_valid(bus.in_d);
    assign ctl_ok_s       = ctl_valid(bus.ctl_d);
    assign any_bad_s      = data_illegal(bus.in_d) | ctl_illegal(bus.ctl_d);
    assign both_neutral_s = (bus.in_d == '0) && (bus.ctl_d == 4'b0000);

    // Enable of the currently selected receiver; a value-3 select never reaches SEND.
    always_comb begin
        case (sel_r)
            2'd0:    sel_e_s = bus.out0_e;
            2'd1:    sel_e_s = bus.out1_e;
            2'd2:    sel_e_s = bus.out2_e;
            default: sel_e_s = 1'b0;
        endcase
    end

    // Next-state, capture, error and output-token logic.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        sel_s   = sel_r;
        err_s   = err_r;
        load_s  = 1'b0;
        tok_s   = '0;
        case (state_r)
            IDLE_PRE: begin
                state_s = IDLE;
            end
            IDLE: begin
                if (any_bad_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                // An illegal pair fails the one-hot test, so it can never capture.
                if (in_ok_s && ctl_ok_s) begin
                    data_s  = data_decode(bus.in_d);
                    sel_s   = ctl_decode(bus.ctl_d);
                    state_s = ACK_IN;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK_IN: begin
                if (any_bad_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (both_neutral_s) begin
                    if (sel_r == 2'd3) begin
                        err_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = ACK_IN;
                end
            end
            SEND: begin
                if (sel_e_s) begin
                    load_s  = 1'b1;
                    tok_s   = data_encode(data_r);
                    state_s = OUT_ACK;
                end else begin
                    state_s = SEND;
                end
            end
            OUT_ACK: begin
                if (!sel_e_s) begin
                    load_s  = 1'b1;
                    tok_s   = '0;
                    state_s = OUT_RST;
                end else begin
                    state_s = OUT_ACK;
                end
            end
            OUT_RST: begin
                if (sel_e_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUT_RST;
                end
            end
            default: begin
                state_s = IDLE_PRE;
            end
        endcase

        for (int k = 0; k < 3; k++) begin
            if (load_s && (sel_r == 2'(k))) begin
                out_s[k] = tok_s;
            end else begin
                out_s[k] = out_r[k];
            end
        end
        en_s = (state_s == IDLE);
    end

    // State and registered outputs; reset abandons any token in flight.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_r <= IDLE_PRE;
            data_r  <= '0;
            sel_r   <= 2'd0;
            err_r   <= 1'b0;
            en_r    <= 1'b0;
            out_r   <= '{default: '0};
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            sel_r   <= sel_s;
            err_r   <= err_s;
            en_r    <= en_s;
            out_r   <= out_s;
        end
    end

    assign bus.in_e   = en_r;
    assign bus.ctl_e  = en_r;
    assign bus.out0_d = out_r[0];
    assign bus.out1_d = out_r[1];
    assign bus.out2_d = out_r[2];
    assign bus.err    = err_r;

endmodule

// File: tb/tb_split_sync.sv
// Randomized scoreboard bench for split_sync: per-output expected-token queues
// form the gold split model; a monitor pops and compares on every delivered token.
module tb_split_sync;
    localparam int W   = 11;
    localparam int LIM = 3000;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    split_sync_if #(.W(W)) bus ();
    split_sync #(.W(W)) dut (.CLK(CLK), ._RESET(rst_n), .bus(bus));

    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q [3][$];
    logic [2:0]     rcv_e;
    logic [2:0]     hold;
    int             max_dly;
    logic [2*W-1:0] od [3];

    assign bus.out0_e = rcv_e[0];
    assign bus.out1_e = rcv_e[1];
    assign bus.out2_e = rcv_e[2];
    assign od[0] = bus.out0_d;
    assign od[1] = bus.out1_d;
    assign od[2] = bus.out2_d;

    function automatic logic [2*W-1:0] enc_d(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [3:0] enc_c(input logic [1:0] v);
        return {v[1], ~v[1], v[0], ~v[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Receivers: toggle enable after a random delay once the output changes phase.
    initial begin
        int   cnt [3];
        logic armed [3];
        logic tc;
        rcv_e = 3'b111;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            armed[k] = 1'b0;
        end
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                tc = rcv_e[k] ? (od[k] != '0) : (od[k] == '0);
                if (hold[k]) begin
                    rcv_e[k] = 1'b0;
                    armed[k] = 1'b0;
                end else if (!tc) begin
                    armed[k] = 1'b0;
                end else if (!armed[k]) begin
                    cnt[k] = $urandom_range(0, max_dly);
                    if (cnt[k] == 0) rcv_e[k] = ~rcv_e[k];
                    else armed[k] = 1'b1;
                end else begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        rcv_e[k] = ~rcv_e[k];
                        armed[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every new output token must be the oldest expected one for that channel.
    initial begin
        logic [2*W-1:0] prev [3];
        logic [W-1:0]   e;
        int             active;
        for (int k = 0; k < 3; k++) prev[k] = '0;
        forever begin
            @(negedge CLK);
            active = 0;
            for (int k = 0; k < 3; k++) if (od[k] != '0) active++;
            for (int k = 0; k < 3; k++) begin
                if (od[k] != '0 && prev[k] == '0) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("out%0d_unexpected", k), {10'd0, od[k]}, 32'd0);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("out%0d_token", k), {10'd0, od[k]}, {10'd0, enc_d(e)});
                        check($sformatf("out%0d_others_neutral", k), active, 32'd1);
                    end
                end
                prev[k] = od[k];
            end
        end
    end

    task automatic send(input logic [W-1:0] data, input logic [1:0] ctl, input int skew);
        int   n;
        logic ok;
        n = 0;
        while (!(bus.in_e && bus.ctl_e) && n < LIM) begin
            @(negedge CLK);
            n++;
        end
        check("send_wait_enable_timeout", n >= LIM, 32'd0);
        if (skew > 0) begin
            ok = 1'b1;
            bus.ctl_d = enc_c(ctl);
            bus.in_d  = '0;
            repeat (skew) begin
                @(negedge CLK);
                ok = ok & bus.in_e & bus.ctl_e;
            end
            check("skew_no_early_capture", ok, 32'd1);
        end
        bus.in_d  = enc_d(data);
        bus.ctl_d = enc_c(ctl);
        if (ctl != 2'd3) exp_q[ctl].push_back(data);
        n = 0;
        @(negedge CLK);
        while (bus.in_e && n < LIM) begin
            @(negedge CLK);
            n++;
        end
        check("send_capture_timeout", n >= LIM, 32'd0);
        bus.in_d  = '0;
        bus.ctl_d = 4'b0000;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || !bus.in_e) && n < LIM) begin
            @(negedge CLK);
            n++;
        end
        check(name, n >= LIM, 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.in_d  = '0;
        bus.ctl_d = 4'b0000;
        repeat (5) @(negedge CLK);
        check("rst_in_e", bus.in_e, 32'd0);
        check("rst_ctl_e", bus.ctl_e, 32'd0);
        check("rst_out0", {10'd0, bus.out0_d}, 32'd0);
        check("rst_out1", {10'd0, bus.out1_d}, 32'd0);
        check("rst_out2", {10'd0, bus.out2_d}, 32'd0);
        check("rst_err", bus.err, 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);
        check("release_in_e", bus.in_e, 32'd1);
        check("release_ctl_e", bus.ctl_e, 32'd1);
    endtask

    initial begin
        logic [2*W-1:0] bad;
        logic           ok;
        hold    = 3'b000;
        max_dly = 0;
        do_reset();

        // Routing to each output with always-ready receivers.
        send(11'd5, 2'd0, 0);
        send(11'd1023, 2'd1, 0);
        send(11'd2047, 2'd2, 0);
        drain("route_drain");

        // Backpressure on out1.
        hold[1] = 1'b1;
        send(11'd42, 2'd1, 0);
        ok = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            ok = ok & (bus.out1_d == '0) & ~bus.in_e & ~bus.ctl_e;
        end
        check("backpressure_hold", ok, 32'd1);
        check("backpressure_pending", exp_q[1].size(), 32'd1);
        hold[1] = 1'b0;
        drain("backpressure_drain");

        // Control arrives four cycles ahead of data.
        send(11'd300, 2'd2, 4);
        drain("skew_drain");

        // Random co-simulation against the gold split model.
        max_dly = 5;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send(W'($urandom), 2'($urandom_range(0, 2)), 0);
        end
        drain("random_drain");
        check("random_err_clear", bus.err, 32'd0);

        // Control value 3 is discarded and flagged.
        max_dly = 0;
        send(11'd9, 2'd3, 0);
        drain("ctl3_drain");
        check("ctl3_err", bus.err, 32'd1);
        send(11'd7, 2'd0, 0);
        drain("after_ctl3_drain");
        check("after_ctl3_err_sticky", bus.err, 32'd1);

        // Illegal pair on in_d bit 0 after a fresh reset.
        do_reset();
        bad       = enc_d(11'd3);
        bad[1:0]  = 2'b11;
        bus.in_d  = bad;
        bus.ctl_d = enc_c(2'd0);
        repeat (3) @(negedge CLK);
        check("illegal_no_capture", bus.in_e, 32'd1);
        check("illegal_err", bus.err, 32'd1);
        bus.in_d  = '0;
        bus.ctl_d = 4'b0000;
        repeat (3) @(negedge CLK);
        check("final_queues_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
